// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-bundle width, control bit positions and register-0 index.
package cpu_pkg;

    localparam int CTRL_W         = 8;
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_ALU_SRC   = 3;
    localparam int CTRL_ALU_OP_LO = 4;
    localparam int CTRL_ALU_OP_HI = 7;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // r0 is hardwired to zero, so it never takes part in forwarding or hazard matches.
    function automatic logic idx_match(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_bypass_mux.sv
// Selects writeback data over a register-read value when the writeback targets that register.
module wb_bypass_mux
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              wb_reg_write_i,
    input  logic [4:0]        wb_reg_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [4:0]        src_reg_i,
    input  logic [DATA_W-1:0] src_data_i,
    output logic [DATA_W-1:0] data_o
);

    assign data_o = (wb_reg_write_i && idx_match(wb_reg_i, src_reg_i)) ? wb_data_i : src_data_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with writeback bypass, load-use bubbles, flush and EX backpressure.
// Optional IDEX_PERF_CNT_EN adds cnt_bubble / cnt_flush event counters.
module id_ex_stage #(
    parameter int CTRL_W = cpu_pkg::CTRL_W,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_dst,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dst,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [CTRL_W-1:0] ex_ctrl
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]       cnt_bubble,
    output logic [31:0]       cnt_flush
`endif
);

    import cpu_pkg::*;

    logic              ex_valid_q, ex_valid_d;
    logic [31:0]       ex_pc_q, ex_pc_d;
    logic [4:0]        ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_dst_q, ex_dst_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d, ex_op1_q, ex_op1_d, ex_op2_q, ex_op2_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;

    logic [DATA_W-1:0] cap_op1, cap_op2, hold_op1, hold_op2;
    logic              load_use;

    wb_bypass_mux #(.DATA_W(DATA_W)) u_cap_op1 (
        .wb_reg_write_i(wb_reg_write), .wb_reg_i(wb_reg), .wb_data_i(wb_data),
        .src_reg_i(id_rs), .src_data_i(rd_data1), .data_o(cap_op1)
    );
    wb_bypass_mux #(.DATA_W(DATA_W)) u_cap_op2 (
        .wb_reg_write_i(wb_reg_write), .wb_reg_i(wb_reg), .wb_data_i(wb_data),
        .src_reg_i(id_rt), .src_data_i(rd_data2), .data_o(cap_op2)
    );
    // Refresh paths keep held operands current while EX is stalled.
    wb_bypass_mux #(.DATA_W(DATA_W)) u_hold_op1 (
        .wb_reg_write_i(wb_reg_write), .wb_reg_i(wb_reg), .wb_data_i(wb_data),
        .src_reg_i(ex_rs_q), .src_data_i(ex_op1_q), .data_o(hold_op1)
    );
    wb_bypass_mux #(.DATA_W(DATA_W)) u_hold_op2 (
        .wb_reg_write_i(wb_reg_write), .wb_reg_i(wb_reg), .wb_data_i(wb_data),
        .src_reg_i(ex_rt_q), .src_data_i(ex_op2_q), .data_o(hold_op2)
    );

    assign load_use = ex_valid_q && ex_ctrl_q[CTRL_MEM_READ] && (ex_dst_q != REG_ZERO) && id_valid
                      && ((id_uses_rs && (id_rs == ex_dst_q)) || (id_uses_rt && (id_rt == ex_dst_q)));

    assign stall_id = !flush && (!ex_ready || load_use);

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_rs_d    = ex_rs_q;
        ex_rt_d    = ex_rt_q;
        ex_dst_d   = ex_dst_q;
        ex_imm_d   = ex_imm_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        ex_ctrl_d  = ex_ctrl_q;
        if (flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else if (!ex_ready) begin
            if (ex_valid_q) begin
                ex_op1_d = hold_op1;
                ex_op2_d = hold_op2;
            end
        end else if (load_use) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else begin
            ex_valid_d = id_valid;
            ex_pc_d    = id_pc;
            ex_rs_d    = id_rs;
            ex_rt_d    = id_rt;
            ex_dst_d   = id_dst;
            ex_imm_d   = id_imm;
            ex_op1_d   = cap_op1;
            ex_op2_d   = cap_op2;
            ex_ctrl_d  = id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_dst_q   <= '0;
            ex_imm_q   <= '0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_ctrl_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_dst_q   <= ex_dst_d;
            ex_imm_q   <= ex_imm_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
            ex_ctrl_q  <= ex_ctrl_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_pc    = ex_pc_q;
    assign ex_rs    = ex_rs_q;
    assign ex_rt    = ex_rt_q;
    assign ex_dst   = ex_dst_q;
    assign ex_imm   = ex_imm_q;
    assign ex_op1   = ex_op1_q;
    assign ex_op2   = ex_op2_q;
    assign ex_ctrl  = ex_ctrl_q;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] cnt_bubble_q, cnt_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_bubble_q <= '0;
            cnt_flush_q  <= '0;
        end else begin
            if (!flush && ex_ready && load_use)
                cnt_bubble_q <= cnt_bubble_q + 32'd1;
            if (flush && (ex_valid_q || id_valid))
                cnt_flush_q <= cnt_flush_q + 32'd1;
        end
    end

    assign cnt_bubble = cnt_bubble_q;
    assign cnt_flush  = cnt_flush_q;
`endif

endmodule
